// File: rtl/mod_n_counter_if.sv
// ---------------------------------------------------------------------------
// mod_n_counter_if
//   Bundles the control inputs and the outputs of one mod_n_counter stage.
//   The clock (CLK) and the reset (rst_n) are not part of this bundle.
//
//   Parameter
//     WIDTH     counter width in bits; must match the counter it connects to
//
//   Signals
//     en        count enable
//     up        direction: 1 = up, 0 = down
//     load      parallel load strobe
//     load_val  value captured on load
//     oQ        registered count
//     oTC       combinational terminal count, used for cascading
//     oDisplay  active-low 7-segment pattern, g..a
//
//   Modports
//     master    drives the controls and observes the outputs (board or bench)
//     slave     the counter itself
// ---------------------------------------------------------------------------
interface mod_n_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] oQ;
  logic             oTC;
  logic [6:0]       oDisplay;

  modport master (
    output en, up, load, load_val,
    input  oQ, oTC, oDisplay
  );

  modport slave (
    input  en, up, load, load_val,
    output oQ, oTC, oDisplay
  );
endinterface

// File: rtl/mod_n_counter.sv
// ---------------------------------------------------------------------------
// mod_n_counter
//   Synchronous up/down modulo-MODULUS counter with:
//   - parallel load, where values at or above MODULUS are clamped to MODULUS-1
//   - a combinational terminal-count output for building multi-digit chains
//   - an active-low 7-segment decode of the low hex digit
//
//   Priority at each rising CLK edge is:
//     reset  >  load  >  count  >  hold
//
//   Parameters
//     WIDTH     counter width, 1..16
//     MODULUS   number of count states, 2..2**WIDTH
//
//   Ports
//     CLK       clock; all state changes on the rising edge
//     rst_n     synchronous active-low reset
//     bus       mod_n_counter_if.slave:
//                 en, up, load, load_val  in
//                 oQ, oTC, oDisplay       out
//
//   Build option
//     COUNTER_SAT_EN   When defined, counting saturates at the ends instead of
//                      wrapping: up holds at MODULUS-1, down holds at 0.
//                      oTC uses the same equation in both modes, so in
//                      saturating mode it stays high while the count is
//                      pinned and en=1.
//                      Default (undefined): the counter wraps around.
// ---------------------------------------------------------------------------
module mod_n_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic           CLK,
  input  logic           rst_n,
  mod_n_counter_if.slave bus
);

  // Elaboration-time range checks
  generate
    if (WIDTH < 1 || WIDTH > 16) begin : g_bad_width
      $error("mod_n_counter: WIDTH=%0d outside 1..16", WIDTH);
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("mod_n_counter: MODULUS=%0d outside 2..2**WIDTH", MODULUS);
    end
  endgenerate

  // The terminal value is held one bit wider than the count. This keeps it
  // representable when MODULUS == 2**WIDTH and lets the step logic detect
  // both overflow and underflow with a single compare.
  localparam int             MAXV  = MODULUS - 1;
  localparam logic [WIDTH:0] MAX_X = MAXV[WIDTH:0];

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH:0]   q_x;
  logic             at_top;
  logic             at_bottom;
  logic [3:0]       digit;

  // Load clamp: an out-of-range load value is stored as MODULUS-1.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
    logic [WIDTH:0] vx;
    vx = {1'b0, v};
    if (vx > MAX_X) begin
      return MAX_X[WIDTH-1:0];
    end
    return v;
  endfunction

  // Increment in WIDTH+1 bits.
  // Anything above MAX_X means the count went past the top, which includes
  // the natural 2**WIDTH overflow.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH:0] cx);
    logic [WIDTH:0] nx;
    nx = cx + 1'b1;
    if (nx > MAX_X) begin
`ifdef COUNTER_SAT_EN
      nx = MAX_X;
`else
      nx = '0;
`endif
    end
    return nx[WIDTH-1:0];
  endfunction

  // Decrement in WIDTH+1 bits.
  // Borrowing below zero sets the extra top bit, so the result compares
  // above MAX_X and takes the same out-of-range path as an overflow.
  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH:0] cx);
    logic [WIDTH:0] nx;
    nx = cx - 1'b1;
    if (nx > MAX_X) begin
`ifdef COUNTER_SAT_EN
      nx = '0;
`else
      nx = MAX_X;
`endif
    end
    return nx[WIDTH-1:0];
  endfunction

  // Active-low segment patterns, bit6 = g ... bit0 = a.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign q_x       = {1'b0, q_q};
  assign at_top    = (q_x == MAX_X);
  assign at_bottom = (q_x == '0);

  // Next-state selection: load > count > hold
  always_comb begin
    q_d = q_q;
    if (bus.load) begin
      q_d = clamp_load(bus.load_val);
    end else if (bus.en) begin
      if (bus.up) begin
        q_d = step_up(q_x);
      end else begin
        q_d = step_down(q_x);
      end
    end
  end

  // Count register (stage boundary)
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Display digit: the low 4 bits of the count, zero-extended when the
  // counter is narrower than 4 bits.
  generate
    if (WIDTH >= 4) begin : g_digit_wide
      assign digit = q_q[3:0];
    end else begin : g_digit_narrow
      assign digit = {{(4 - WIDTH){1'b0}}, q_q};
    end
  endgenerate

  assign bus.oQ = q_q;

  // oTC goes high in the cycle before the wrap edge, so a downstream stage
  // with en = oTC advances on exactly that edge.
  // load and reset suppress it because they pre-empt the step.
  assign bus.oTC = bus.en & ~bus.load & rst_n & (bus.up ? at_top : at_bottom);

  assign bus.oDisplay = seg_decode(digit);

endmodule
